// File: rtl/piso_unloader8_pkg.sv
// Shared definitions for the parallel-in/serial-out unloader and its companion receiver.
// Holds the FSM state encodings and the valid/ready handshake-beat macro.
`ifndef PIU_HS_BEAT
`define PIU_HS_BEAT(v, r) ((v) & (r))
`endif

package piso_unloader8_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bits needed to index WIDTH beats; never less than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_unloader8_bit_counter.sv
// Beat counter for the unloader: sync clear, count enable and terminal-count flag.
// The terminal count marks the final bit of the word being shifted out.
module piso_unloader8_bit_counter #(
  parameter int CNT_W    = 3,
  parameter int TERMINAL = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tc = (r_count == CNT_W'(TERMINAL));

endmodule

// File: rtl/piso_unloader8.sv
// Parallel-in/serial-out unloader: takes a WIDTH-bit word on a valid/ready load port
// and emits it one bit per accepted beat, with zero-bubble reload on the last beat.
module piso_unloader8
  import piso_unloader8_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_shifted;
  logic             w_out_bit;
  logic             w_tc;
  logic             w_load;
  logic             w_beat;

  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign w_out_bit      = r_sreg[0];
      assign w_sreg_shifted = {1'b0, r_sreg[WIDTH-1:1]};
    end else begin : g_msb
      assign w_out_bit      = r_sreg[WIDTH-1];
      assign w_sreg_shifted = {r_sreg[WIDTH-2:0], 1'b0};
    end
  endgenerate

  assign w_load = load_valid & load_ready;
  assign w_beat = `PIU_HS_BEAT(sout_valid, sout_ready);

  // Counter restarts on every capture and after the final beat, so it stays below WIDTH.
  piso_unloader8_bit_counter #(
    .CNT_W    (CNT_W),
    .TERMINAL (WIDTH - 1)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (w_load | (w_beat & w_tc)),
    .en  (w_beat),
    .tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_sreg <= d;
      end else if (w_beat) begin
        r_sreg <= w_sreg_shifted;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    sout_valid  = 1'b0;
    sout        = 1'b0;
    sout_last   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        sout_valid = 1'b1;
        sout       = w_out_bit;
        sout_last  = w_tc;
        // Last-beat acceptance opens the load port in the same cycle for back-to-back words.
        load_ready = w_tc & sout_ready;
        if (w_tc && sout_ready && !load_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_unloader8.sv
// Directed bench for piso_unloader8: an 8-bit LSB-first instance and a 4-bit MSB-first instance.
module tb_piso_unloader8;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid, load_ready, sout, sout_valid, sout_ready, sout_last;
  logic [7:0] d;
  logic       b_load_valid, b_load_ready, b_sout, b_sout_valid, b_sout_ready, b_sout_last;
  logic [3:0] b_d;

  int total = 0;
  int bad   = 0;
  logic [15:0] seq;

  always #5 clk = ~clk;

  piso_unloader8 #(.WIDTH(8), .LSB_FIRST(1)) dut_a (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .d(d),
    .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready), .sout_last(sout_last)
  );

  piso_unloader8 #(.WIDTH(4), .LSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst), .load_valid(b_load_valid), .load_ready(b_load_ready), .d(b_d),
    .sout(b_sout), .sout_valid(b_sout_valid), .sout_ready(b_sout_ready), .sout_last(b_sout_last)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; d = 8'h00; sout_ready = 1'b0;
    b_load_valid = 1'b0; b_d = 4'h0; b_sout_ready = 1'b0;

    // 1: reset
    cyc(); cyc();
    rst = 1'b0; #1;
    chk("rst_load_ready", load_ready, 1'b1);
    chk("rst_sout_valid", sout_valid, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_sout_last", sout_last, 1'b0);
    chk("rst_b_load_ready", b_load_ready, 1'b1);

    // 2: 8'hA5 LSB first -> 1,0,1,0,0,1,0,1 (seq[i] = i-th emitted bit)
    seq = 16'h00A5;
    load_valid = 1'b1; d = 8'hA5; sout_ready = 1'b1; #1;
    chk("a5_load_ready", load_ready, 1'b1);
    cyc();
    load_valid = 1'b0; d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("a5_valid%0d", i), sout_valid, 1'b1);
      chk($sformatf("a5_bit%0d", i), sout, seq[i]);
      chk($sformatf("a5_last%0d", i), sout_last, (i == 7));
      cyc();
    end
    #1;
    chk("a5_idle_valid", sout_valid, 1'b0);
    chk("a5_idle_ready", load_ready, 1'b1);

    // 3: 8'h3C with 3-cycle stall after bit 2 -> 0,0,1,1,1,1,0,0
    seq = 16'h003C;
    load_valid = 1'b1; d = 8'h3C; cyc();
    load_valid = 1'b0; d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        sout_ready = 1'b0; load_valid = 1'b1; d = 8'hFF;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk($sformatf("3c_stall_valid%0d", s), sout_valid, 1'b1);
          chk($sformatf("3c_stall_bit%0d", s), sout, 1'b1);
          chk($sformatf("3c_stall_last%0d", s), sout_last, 1'b0);
          chk($sformatf("3c_stall_lready%0d", s), load_ready, 1'b0);
          cyc();
        end
        sout_ready = 1'b1; load_valid = 1'b0; d = 8'h00;
      end
      #1;
      chk($sformatf("3c_bit%0d", i), sout, seq[i]);
      chk($sformatf("3c_last%0d", i), sout_last, (i == 7));
      cyc();
    end
    #1;
    chk("3c_idle_valid", sout_valid, 1'b0);

    // 4: 8'hFF then 8'h00 back to back -> eight 1s then eight 0s, no gap
    seq = 16'h00FF;
    load_valid = 1'b1; d = 8'hFF; cyc();
    d = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) load_valid = 1'b0;
      #1;
      chk($sformatf("b2b_valid%0d", i), sout_valid, 1'b1);
      chk($sformatf("b2b_bit%0d", i), sout, seq[i]);
      chk($sformatf("b2b_last%0d", i), sout_last, (i == 7) || (i == 15));
      chk($sformatf("b2b_lready%0d", i), load_ready, (i == 7) || (i == 15));
      cyc();
    end
    #1;
    chk("b2b_idle_valid", sout_valid, 1'b0);

    // 5: 8'h96 reset after bit 4 -> 0,1,1,0,1 then nothing
    seq = 16'h0096;
    load_valid = 1'b1; d = 8'h96; cyc();
    load_valid = 1'b0; d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("96_bit%0d", i), sout, seq[i]);
      cyc();
    end
    rst = 1'b1; cyc();
    rst = 1'b0; #1;
    chk("96_rst_valid", sout_valid, 1'b0);
    chk("96_rst_sout", sout, 1'b0);
    chk("96_rst_last", sout_last, 1'b0);
    chk("96_rst_lready", load_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk($sformatf("96_after_valid%0d", i), sout_valid, 1'b0);
    end

    // 6: WIDTH=4 MSB first, 4'b1000 -> 1,0,0,0
    seq = 16'h0001;
    b_load_valid = 1'b1; b_d = 4'b1000; b_sout_ready = 1'b1; #1;
    chk("w4_load_ready", b_load_ready, 1'b1);
    cyc();
    b_load_valid = 1'b0; b_d = 4'h0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("w4_valid%0d", i), b_sout_valid, 1'b1);
      chk($sformatf("w4_bit%0d", i), b_sout, seq[i]);
      chk($sformatf("w4_last%0d", i), b_sout_last, (i == 3));
      cyc();
    end
    #1;
    chk("w4_idle_valid", b_sout_valid, 1'b0);
    chk("w4_idle_ready", b_load_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
